// File: rtl/blink_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// blink_scheduler_pkg
// Shared types and constants for the blink scheduler:
//   - state_e       : sequencer states (IDLE, ON, OFF, GAP)
//   - DEF_*         : default parameter values
//   - clog2_min1()  : ceiling log2 that never returns less than 1, used to
//                     size index and counter fields that must be at least
//                     one bit wide even for degenerate parameter values.
// -----------------------------------------------------------------------------
package blink_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    localparam int DEF_REQUESTERS  = 4;
    localparam int DEF_HALF_PERIOD = 10;
    localparam int DEF_GAP_CYCLES  = 40;
    localparam int DEF_COUNT_WIDTH = 4;

    function automatic int clog2_min1(input int value);
        int bits;
        bits = $clog2(value);
        if (bits < 1) begin
            return 1;
        end else begin
            return bits;
        end
    endfunction

endpackage

// File: rtl/blink_scheduler_if.sv
// -----------------------------------------------------------------------------
// blink_scheduler_if
// Bundles the requester-facing and LED-facing signals of the scheduler.
//   request   : per-requester request level            (requesters -> sched)
//   count     : packed blink counts, slice i = req i    (requesters -> sched)
//   ack       : one-hot, one-cycle acceptance pulse     (sched -> requesters)
//   busy      : a burst or trailing gap is in progress  (sched -> requesters)
//   active_id : index of the requester being served     (sched -> requesters)
//   blinker   : registered LED drive                    (sched -> LED pin)
// Modports: master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface blink_scheduler_if
    import blink_scheduler_pkg::*;
#(
    parameter int REQUESTERS  = DEF_REQUESTERS,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
);
    localparam int ID_W = clog2_min1(REQUESTERS);

    logic [REQUESTERS-1:0]             request;
    logic [REQUESTERS*COUNT_WIDTH-1:0] count;
    logic [REQUESTERS-1:0]             ack;
    logic                              busy;
    logic [ID_W-1:0]                   active_id;
    logic                              blinker;

    modport master (
        output request,
        output count,
        input  ack,
        input  busy,
        input  active_id,
        input  blinker
    );

    modport slave (
        input  request,
        input  count,
        output ack,
        output busy,
        output active_id,
        output blinker
    );

endinterface

// File: rtl/blink_rr_arbiter.sv
// -----------------------------------------------------------------------------
// blink_rr_arbiter
// Purely combinational round-robin arbiter. Priority starts at ptr_i and wraps
// around the request vector; the first asserted request found wins.
//   req_i   : request vector
//   ptr_i   : index of the current highest-priority requester
//   grant_o : one-hot grant (all zero when nothing is requested)
//   idx_o   : binary index of the winner (0 when nothing is requested)
//   valid_o : at least one request is pending
// -----------------------------------------------------------------------------
module blink_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int          cand_int;
    logic [IW-1:0] cand_idx;

    // Scan from the farthest offset down to offset 0 so the requester closest
    // to the pointer is written last and therefore wins.
    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand_int = 0;
        cand_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand_int = (int'(ptr_i) + i) % N;
            cand_idx = IW'(cand_int);
            if (req_i[cand_idx]) begin
                grant_o           = '0;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
                valid_o           = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/blink_scheduler.sv
// -----------------------------------------------------------------------------
// blink_scheduler
// Shares one LED among several requesters. In IDLE a round-robin arbiter picks
// one pending request, latches its blink count, pulses ack and then plays the
// burst: HALF_PERIOD cycles on, HALF_PERIOD cycles off, per blink, followed by
// GAP_CYCLES dark cycles before the next grant. Requests seen outside IDLE are
// ignored. All outputs are registered.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset
//   bus   : blink_scheduler_if.slave (request, count, ack, busy, active_id,
//           blinker)
// Optional feature macro: BLINK_SCHEDULER_IDLE_HEARTBEAT_EN
//   defined   -> blinker toggles every HALF_PERIOD cycles while IDLE,
//                restarting low on every IDLE entry
//   undefined -> blinker is held low while IDLE
// -----------------------------------------------------------------------------
module blink_scheduler
    import blink_scheduler_pkg::*;
#(
    parameter int REQUESTERS  = DEF_REQUESTERS,
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    blink_scheduler_if.slave  bus
);

    localparam int ID_W     = clog2_min1(REQUESTERS);
    localparam int MAX_PH   = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int PH_W     = clog2_min1(MAX_PH + 1);
    localparam bit HAS_GAP  = (GAP_CYCLES > 0);

    // Phase counters count down from (length-1) to 0, reloaded on each state entry.
    localparam logic [PH_W-1:0]        HP_LOAD  = PH_W'(HALF_PERIOD - 1);
    localparam logic [PH_W-1:0]        GAP_LOAD = PH_W'(HAS_GAP ? (GAP_CYCLES - 1) : 0);
    localparam logic [PH_W-1:0]        PH_ONE   = PH_W'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [COUNT_WIDTH-1:0]  rem_q, rem_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [REQUESTERS-1:0]   ack_q, ack_d;
    logic                    busy_q, busy_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic                    blinker_q, blinker_d;
`ifdef BLINK_SCHEDULER_IDLE_HEARTBEAT_EN
    logic                    hb_q, hb_d;
`endif

    logic [REQUESTERS-1:0]   arb_grant_s;
    logic [ID_W-1:0]         arb_idx_s;
    logic                    arb_valid_s;
    logic [COUNT_WIDTH-1:0]  win_count_s;
    logic                    grant_s;

    blink_rr_arbiter #(
        .N  (REQUESTERS),
        .IW (ID_W)
    ) u_arb (
        .req_i   (bus.request),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s),
        .valid_o (arb_valid_s)
    );

    // Count slice of the arbitration winner; only used on the grant edge.
    assign win_count_s = bus.count[int'(arb_idx_s) * COUNT_WIDTH +: COUNT_WIDTH];
    assign grant_s     = (state_q == S_IDLE) && arb_valid_s;

    // Next-state, counter and output computation for the sequencer.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        id_d    = id_q;
`ifdef BLINK_SCHEDULER_IDLE_HEARTBEAT_EN
        // Any path other than staying in IDLE without a grant restarts low.
        hb_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_s) begin
                    ack_d = arb_grant_s;
                    id_d  = arb_idx_s;
                    ptr_d = ID_W'((int'(arb_idx_s) + 1) % REQUESTERS);
                    rem_d = win_count_s;
                    if (win_count_s != '0) begin
                        state_d = S_ON;
                        phase_d = HP_LOAD;
                    end else if (HAS_GAP) begin
                        state_d = S_GAP;
                        phase_d = GAP_LOAD;
                    end else begin
                        // Empty burst with no gap: one busy cycle, back to IDLE.
                        state_d = S_IDLE;
                        phase_d = HP_LOAD;
                    end
                end else if (phase_q == '0) begin
                    // Idle phase counter doubles as the heartbeat timer.
                    phase_d = HP_LOAD;
`ifdef BLINK_SCHEDULER_IDLE_HEARTBEAT_EN
                    hb_d    = ~hb_q;
`endif
                end else begin
                    phase_d = phase_q - PH_ONE;
`ifdef BLINK_SCHEDULER_IDLE_HEARTBEAT_EN
                    hb_d    = hb_q;
`endif
                end
            end
            S_ON: begin
                if (phase_q == '0) begin
                    state_d = S_OFF;
                    phase_d = HP_LOAD;
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end
            S_OFF: begin
                if (phase_q == '0) begin
                    rem_d = rem_q - CNT_ONE;
                    if (rem_q != CNT_ONE) begin
                        state_d = S_ON;
                        phase_d = HP_LOAD;
                    end else if (HAS_GAP) begin
                        state_d = S_GAP;
                        phase_d = GAP_LOAD;
                    end else begin
                        state_d = S_IDLE;
                        phase_d = HP_LOAD;
                    end
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end
            S_GAP: begin
                if (phase_q == '0) begin
                    state_d = S_IDLE;
                    phase_d = HP_LOAD;
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = HP_LOAD;
            end
        endcase

        // busy covers the ack cycle even when an empty burst returns to IDLE.
        busy_d    = grant_s || (state_d != S_IDLE);
        blinker_d = (state_d == S_ON);
`ifdef BLINK_SCHEDULER_IDLE_HEARTBEAT_EN
        if (state_d == S_IDLE) begin
            blinker_d = hb_d;
        end else begin
            blinker_d = (state_d == S_ON);
        end
`endif
    end

    // State, counter, pointer and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= HP_LOAD;
            rem_q     <= '0;
            ptr_q     <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            id_q      <= '0;
            blinker_q <= 1'b0;
`ifdef BLINK_SCHEDULER_IDLE_HEARTBEAT_EN
            hb_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            rem_q     <= rem_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            id_q      <= id_d;
            blinker_q <= blinker_d;
`ifdef BLINK_SCHEDULER_IDLE_HEARTBEAT_EN
            hb_q      <= hb_d;
`endif
        end
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.active_id = id_q;
    assign bus.blinker   = blinker_q;

endmodule

// File: tb/tb_blink_scheduler.sv
// -----------------------------------------------------------------------------
// tb_blink_scheduler
// Directed self-checking bench for blink_scheduler with default parameters
// (4 requesters, half period 10, gap 40, 4-bit counts). Inputs are driven and
// outputs sampled on the falling clock edge. The idle-blinker scenario adapts
// its expectation to BLINK_SCHEDULER_IDLE_HEARTBEAT_EN.
// -----------------------------------------------------------------------------
module tb_blink_scheduler;

    logic        clock;
    logic        reset;
    logic [3:0]  request;
    logic [15:0] count;

    int total;
    int bad;

    blink_scheduler_if #(.REQUESTERS(4), .COUNT_WIDTH(4)) bus ();

    assign bus.request = request;
    assign bus.count   = count;

    blink_scheduler #(
        .REQUESTERS  (4),
        .HALF_PERIOD (10),
        .GAP_CYCLES  (40),
        .COUNT_WIDTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset   = 1'b1;
        request = 4'b1111;
        count   = 16'h1111;
        @(posedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if (bus.blinker !== 1'b0 || bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d blinker=%b ack=%b busy=%b want 0/0000/0",
                         i, bus.blinker, bus.ack, bus.busy);
            end
        end
        reset   = 1'b0;
        request = 4'b0000;
        @(negedge clock);
        total++;
        if (bus.blinker !== 1'b0 || bus.ack !== 4'b0000 || bus.busy !== 1'b0 ||
            bus.active_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_release blinker=%b ack=%b busy=%b id=%0d want 0/0000/0/0",
                     bus.blinker, bus.ack, bus.busy, bus.active_id);
        end
    endtask

    // Requesters 0 and 2 held high with count 1: grants go 0, 2, 0.
    task automatic test_round_robin();
        logic [1:0] exp_id;
        logic [3:0] exp_ack;
        request = 4'b0101;
        count   = 16'h0101;
        for (int g = 0; g < 3; g++) begin
            exp_id  = (g == 1) ? 2'd2 : 2'd0;
            exp_ack = 4'b0001 << exp_id;
            @(negedge clock);
            total++;
            if (bus.ack !== exp_ack || bus.active_id !== exp_id || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL rr_grant g=%0d ack=%b id=%0d busy=%b want %b/%0d/1",
                         g, bus.ack, bus.active_id, bus.busy, exp_ack, exp_id);
            end
            if (g == 2) request = 4'b0000;
            for (int c = 1; c < 60; c++) begin
                @(negedge clock);
                total++;
                if (bus.busy !== 1'b1 || bus.ack !== 4'b0000) begin
                    bad++;
                    $display("FAIL rr_window g=%0d c=%0d busy=%b ack=%b want 1/0000",
                             g, c, bus.busy, bus.ack);
                end
            end
            @(negedge clock);
            total++;
            if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
                bad++;
                $display("FAIL rr_end g=%0d busy=%b ack=%b want 0/0000", g, bus.busy, bus.ack);
            end
        end
    endtask

    // Requester 1, count 3: three 10/10 blinks, 40 dark cycles, busy for 100.
    task automatic test_single_burst();
        logic exp_blink;
        request = 4'b0010;
        count   = 16'h0030;
        @(negedge clock);
        total++;
        if (bus.ack !== 4'b0010 || bus.busy !== 1'b1 || bus.blinker !== 1'b1 ||
            bus.active_id !== 2'd1) begin
            bad++;
            $display("FAIL burst_grant ack=%b busy=%b blinker=%b id=%0d want 0010/1/1/1",
                     bus.ack, bus.busy, bus.blinker, bus.active_id);
        end
        request = 4'b0000;
        for (int c = 1; c < 100; c++) begin
            @(negedge clock);
            exp_blink = (c < 60) && ((c % 20) < 10);
            total++;
            if (bus.blinker !== exp_blink || bus.busy !== 1'b1 || bus.ack !== 4'b0000 ||
                bus.active_id !== 2'd1) begin
                bad++;
                $display("FAIL burst_cycle c=%0d blinker=%b busy=%b ack=%b id=%0d want %b/1/0000/1",
                         c, bus.blinker, bus.busy, bus.ack, bus.active_id, exp_blink);
            end
        end
        @(negedge clock);
        total++;
        if (bus.busy !== 1'b0 || bus.blinker !== 1'b0) begin
            bad++;
            $display("FAIL burst_end busy=%b blinker=%b want 0/0", bus.busy, bus.blinker);
        end
    endtask

    // Requester 3, count 0: ack pulse, dark, busy for exactly the 40-cycle gap.
    task automatic test_zero_count();
        request = 4'b1000;
        count   = 16'h0000;
        @(negedge clock);
        total++;
        if (bus.ack !== 4'b1000 || bus.busy !== 1'b1 || bus.blinker !== 1'b0 ||
            bus.active_id !== 2'd3) begin
            bad++;
            $display("FAIL zero_grant ack=%b busy=%b blinker=%b id=%0d want 1000/1/0/3",
                     bus.ack, bus.busy, bus.blinker, bus.active_id);
        end
        request = 4'b0000;
        for (int c = 1; c < 40; c++) begin
            @(negedge clock);
            total++;
            if (bus.busy !== 1'b1 || bus.blinker !== 1'b0 || bus.ack !== 4'b0000) begin
                bad++;
                $display("FAIL zero_gap c=%0d busy=%b blinker=%b ack=%b want 1/0/0000",
                         c, bus.busy, bus.blinker, bus.ack);
            end
        end
        @(negedge clock);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_end busy=%b want 0", bus.busy);
        end
    endtask

    // Requester 2, count 2, reset on 5th ON cycle; pointer must return to 0.
    // Returns on the first IDLE cycle after the follow-up grant's burst.
    task automatic test_reset_mid_burst();
        request = 4'b0100;
        count   = 16'h0200;
        @(negedge clock);
        request = 4'b0000;
        for (int c = 1; c < 5; c++) begin
            @(negedge clock);
        end
        total++;
        if (bus.blinker !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_on blinker=%b busy=%b want 1/1", bus.blinker, bus.busy);
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (bus.blinker !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 4'b0000 ||
            bus.active_id !== 2'd0) begin
            bad++;
            $display("FAIL midrst_out blinker=%b busy=%b ack=%b id=%0d want 0/0/0000/0",
                     bus.blinker, bus.busy, bus.ack, bus.active_id);
        end
        reset   = 1'b0;
        request = 4'b1001;
        count   = 16'h1001;
        @(negedge clock);
        total++;
        if (bus.ack !== 4'b0001 || bus.active_id !== 2'd0) begin
            bad++;
            $display("FAIL midrst_regrant ack=%b id=%0d want 0001/0", bus.ack, bus.active_id);
        end
        request = 4'b0000;
        for (int c = 1; c < 60; c++) begin
            @(negedge clock);
        end
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_last busy=%b want 1", bus.busy);
        end
        @(negedge clock);
    endtask

    // Entered on the first IDLE cycle; no requests for 45 cycles.
    task automatic test_idle_blinker();
        logic exp_blink;
        for (int e = 0; e < 45; e++) begin
            if (e > 0) @(negedge clock);
`ifdef BLINK_SCHEDULER_IDLE_HEARTBEAT_EN
            exp_blink = ((e / 10) % 2) == 1;
`else
            exp_blink = 1'b0;
`endif
            total++;
            if (bus.blinker !== exp_blink || bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
                bad++;
                $display("FAIL idle_blinker e=%0d blinker=%b busy=%b ack=%b want %b/0/0000",
                         e, bus.blinker, bus.busy, bus.ack, exp_blink);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        request = 4'b0000;
        count   = 16'h0000;
        test_reset();
        test_round_robin();
        test_single_burst();
        test_zero_count();
        test_reset_mid_burst();
        test_idle_blinker();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blink_scheduler.md
# blink_scheduler

Shares a single LED blinker output among several requesters, each asking for a burst of N blinks. A round-robin arbiter picks one pending request. A sequencer FSM then plays that burst with a fixed half-period and a trailing dark gap before serving the next request. It sits between status sources (error, activity, boot-stage reporters) and the board LED pin.

## Interface

- REQUESTERS, 4: number of requesters, ≥1
- HALF_PERIOD, 10: cycles per on-phase and per off-phase of one blink, ≥1
- GAP_CYCLES, 40: dark cycles after a burst, ≥0
- COUNT_WIDTH, 4: width of each blink count
- clock  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high reset
- request  input  REQUESTERS  per-requester request level
- count  input  REQUESTERS*COUNT_WIDTH  packed blink counts; slice i belongs to requester i
- ack  output  REQUESTERS  one-hot, one-cycle acceptance pulse
- busy  output  1  a burst or gap is in progress
- active_id  output  $clog2(REQUESTERS) (min 1)  index of the requester being served
- blinker  output  1  LED drive, registered

## Operation

- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - Arbitration happens only on an IDLE edge with request≠0.
  - Round-robin: priority starts at the pointer and wraps. The pointer moves to winner+1 mod REQUESTERS after each grant.
  - The winner's count is latched.
  - ack[winner] pulses, busy rises, and active_id is updated.
  - Next state: ON if count≠0. If count=0: GAP when GAP_CYCLES>0, otherwise IDLE.
- ON:
  - blinker=1 for HALF_PERIOD cycles, then go to OFF.
- OFF:
  - blinker=0 for HALF_PERIOD cycles, then decrement the remaining count.
  - Remaining >0: go to ON.
  - Otherwise: go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP:
  - blinker=0 for GAP_CYCLES cycles, then go to IDLE.
- Requests outside IDLE are ignored, not queued. Dropping request mid-burst does not abort the burst.
- A requester must drop request in its ack cycle. A request still high at the following IDLE edge is a new request.
- count is sampled only at the grant edge.
- Count width: the burst counter is COUNT_WIDTH bits, so the maximum burst is 2^COUNT_WIDTH−1 blinks.
- Phase counter width: $clog2(max(HALF_PERIOD,GAP_CYCLES)+1) bits; it reloads on every state entry.

## Timing

- Reset values: blinker=0, ack=0, busy=0, active_id=0, state IDLE, RR pointer=0 (requester 0 highest priority).
- Reset mid-burst: outputs return to reset values on the next edge, the burst is discarded and the pointer returns to 0.
- Grant latency: if request is high before edge k in IDLE, then in cycle k+1 ack, busy and blinker (count≠0) are all high.
- Burst duration: busy stays high for exactly 2·HALF_PERIOD·count + GAP_CYCLES cycles.
  - count=0 with GAP_CYCLES=0 is the exception: busy lasts 1 cycle.
- Next-grant latency: the earliest next ack comes 1 cycle after busy falls (the IDLE arbitration edge).
- All outputs are registered; no combinational input-to-output paths.

## Configuration

- BLINK_SCHEDULER_IDLE_HEARTBEAT_EN:
  - Defined: in IDLE, blinker is a free-running heartbeat toggling every HALF_PERIOD cycles, starting low after reset. The heartbeat counter restarts on every IDLE entry. Grants behave as without the macro.
  - Undefined: blinker=0 in IDLE.

## Structure

- Package blink_scheduler_pkg holds:
  - the state enum (IDLE, ON, OFF, GAP);
  - default parameter constants;
  - a clog2-with-minimum-1 helper function.
- Sub-module blink_rr_arbiter:
  - inputs: request vector, pointer;
  - outputs: one-hot grant, index, valid;
  - purely combinational.
- The FSM, counters and pointer register live in blink_scheduler.

## Test plan

All cases use defaults (REQUESTERS=4, HALF_PERIOD=10, GAP_CYCLES=40).

- Reset held 5 cycles with request=4'b1111 → blinker=0, ack=0, busy=0 throughout and in the cycle after release.
- request[1]=1, count[1]=3 → ack=4'b0010 for one cycle. Then blinker high 10 / low 10, three times, then 40 low. busy=1 for 100 cycles and active_id=1.
- request[0] and request[2] held, count=1 each → ack[0] first. The next grant goes to 2 (pointer=1), then 0. Each busy window is 60 cycles.
- request[3]=1, count[3]=0 → ack[3] pulse, blinker stays 0, busy=1 for 40 cycles.
- reset asserted on the 5th ON cycle of a count=2 burst → blinker=0 and busy=0 the next cycle. A subsequent simultaneous request on 0 and 3 grants 0.
- With BLINK_SCHEDULER_IDLE_HEARTBEAT_EN and no requests → blinker toggles every 10 cycles, and ack/busy stay 0. Without the macro → blinker constant 0.
